// File: rtl/multi_tick_gen_pkg.sv
// ----------------------------------------------------------------------------
// multi_tick_gen_pkg
//   Shared constants and types for the multi-channel tick generator.
//   CNT_W_DEF       default counter/divisor width
//   DEFAULT_DIV_DEF divisor loaded into every channel at reset
//   cnt_t           counter/divisor type at the default width
// ----------------------------------------------------------------------------
package multi_tick_gen_pkg;

    localparam int          CNT_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 350000;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage : multi_tick_gen_pkg

// File: rtl/multi_tick_gen_channel.sv
// ----------------------------------------------------------------------------
// tick_gen_channel
//   One tick channel: a free-running counter that emits a registered one-cycle
//   tick every (div_active+1) cycles, plus a shadow divisor that is applied
//   only at a period boundary so every period is glitch-free.
//
//   Optional feature macro: MULTI_TICK_GEN_SQUARE_EN adds the sq output, a
//   flop toggling on every tick (square wave of period 2*(div+1)).
//
// Ports
//   clk       in   1      clock, posedge
//   rst_n     in   1      asynchronous reset, active-low
//   en        in   1      run enable; low holds the counter at 0
//   sync_clr  in   1      synchronous clear; applies any pending shadow
//   wr_sel    in   1      a divisor write targets this channel this cycle
//   wr_div    in   CNT_W  divisor value for the write
//   tick      out  1      registered one-cycle tick
//   pending   out  1      shadow divisor waiting to be applied
//   sq        out  1      square wave (only with MULTI_TICK_GEN_SQUARE_EN)
// ----------------------------------------------------------------------------
module tick_gen_channel
    import multi_tick_gen_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             pending
`ifdef MULTI_TICK_GEN_SQUARE_EN
    ,
    output logic             sq
`endif
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_reg,        cnt_next;
    logic [CNT_W-1:0] div_active_reg, div_active_next;
    logic [CNT_W-1:0] div_shadow_reg, div_shadow_next;
    logic             pending_reg,    pending_next;
    logic             tick_reg,       tick_next;
`ifdef MULTI_TICK_GEN_SQUARE_EN
    logic             sq_reg,         sq_next;
`endif

    logic terminal;
    logic apply_now;

    // Terminal count only exists while running; a disabled channel sits at 0.
    assign terminal = en && (cnt_reg == div_active_reg);

    // Points where a new divisor may take effect without cutting a period
    // short: a clear, a stopped channel, or the end of the current period.
    assign apply_now = sync_clr || !en || terminal;

    always_comb begin
        cnt_next        = cnt_reg;
        div_active_next = div_active_reg;
        div_shadow_next = div_shadow_reg;
        pending_next    = pending_reg;
        tick_next       = 1'b0;
`ifdef MULTI_TICK_GEN_SQUARE_EN
        sq_next         = sq_reg;
`endif

        // The shadow always tracks the latest write, so back-to-back writes
        // resolve to the last one.
        if (wr_sel) begin
            div_shadow_next = wr_div;
        end

        if (apply_now) begin
            cnt_next = '0;
            // A write landing on an apply point bypasses the shadow entirely,
            // so pending never rises for it.
            if (wr_sel) begin
                div_active_next = wr_div;
                pending_next    = 1'b0;
            end else if (pending_reg) begin
                div_active_next = div_shadow_reg;
                pending_next    = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (wr_sel) begin
                pending_next = 1'b1;
            end
        end

        // sync_clr outranks counting: a terminal count in the same cycle
        // still produces no tick.
        if (terminal && !sync_clr) begin
            tick_next = 1'b1;
`ifdef MULTI_TICK_GEN_SQUARE_EN
            sq_next   = ~sq_reg;
`endif
        end

`ifdef MULTI_TICK_GEN_SQUARE_EN
        if (sync_clr) begin
            sq_next = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            div_active_reg <= RST_DIV;
            div_shadow_reg <= RST_DIV;
            pending_reg    <= 1'b0;
            tick_reg       <= 1'b0;
`ifdef MULTI_TICK_GEN_SQUARE_EN
            sq_reg         <= 1'b0;
`endif
        end else begin
            cnt_reg        <= cnt_next;
            div_active_reg <= div_active_next;
            div_shadow_reg <= div_shadow_next;
            pending_reg    <= pending_next;
            tick_reg       <= tick_next;
`ifdef MULTI_TICK_GEN_SQUARE_EN
            sq_reg         <= sq_next;
`endif
        end
    end

    assign tick    = tick_reg;
    assign pending = pending_reg;
`ifdef MULTI_TICK_GEN_SQUARE_EN
    assign sq      = sq_reg;
`endif

endmodule : tick_gen_channel

// File: rtl/multi_tick_gen.sv
// ----------------------------------------------------------------------------
// multi_tick_gen
//   NUM_CH independent tick channels, each emitting a one-cycle tick every
//   (div+1) cycles with a run-time programmable divisor. Feeds update strobes
//   to the game FSMs (paddle, ball, display refresh).
//
//   Optional feature macro: MULTI_TICK_GEN_SQUARE_EN adds sq_out, one square
//   wave per channel toggling on each tick.
//
// Ports
//   clk          in   1        clock, posedge
//   rst_n        in   1        asynchronous reset, active-low
//   en           in   NUM_CH   per-channel run enable
//   sync_clr     in   1        synchronous clear of all channels
//   wr_en        in   1        divisor write strobe (accepted every cycle)
//   wr_ch        in   CH_W     channel index for the write
//   wr_div       in   CNT_W    new divisor value
//   wr_ack       out  1        pulse the cycle after a write to a valid channel
//   wr_err       out  1        pulse the cycle after a write with wr_ch >= NUM_CH
//   div_pending  out  NUM_CH   shadow divisor waiting to be applied
//   tick         out  NUM_CH   registered one-cycle tick per channel
//   sq_out       out  NUM_CH   square waves (only with MULTI_TICK_GEN_SQUARE_EN)
// ----------------------------------------------------------------------------
module multi_tick_gen
    import multi_tick_gen_pkg::*;
#(
    parameter  int          NUM_CH      = 4,
    parameter  int          CNT_W       = CNT_W_DEF,
    parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int          CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [NUM_CH-1:0] div_pending,
    output logic [NUM_CH-1:0] tick
`ifdef MULTI_TICK_GEN_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] sq_out
`endif
);

    // One extra bit so NUM_CH itself is representable when it is a power of 2.
    localparam logic [CH_W:0] NUM_CH_EXT = (CH_W+1)'(NUM_CH);

    logic              wr_ch_valid;
    logic [NUM_CH-1:0] wr_sel;
    logic              wr_ack_reg, wr_ack_next;
    logic              wr_err_reg, wr_err_next;

    assign wr_ch_valid = ({1'b0, wr_ch} < NUM_CH_EXT);

    always_comb begin
        wr_ack_next = wr_en &&  wr_ch_valid;
        wr_err_next = wr_en && !wr_ch_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            wr_ack_reg <= wr_ack_next;
            wr_err_reg <= wr_err_next;
        end
    end

    assign wr_ack = wr_ack_reg;
    assign wr_err = wr_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // An out-of-range index selects nothing, so no channel changes.
            assign wr_sel[gi] = wr_en && wr_ch_valid && (wr_ch == CH_W'(gi));

            tick_gen_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en[gi]),
                .sync_clr (sync_clr),
                .wr_sel   (wr_sel[gi]),
                .wr_div   (wr_div),
                .tick     (tick[gi]),
                .pending  (div_pending[gi])
`ifdef MULTI_TICK_GEN_SQUARE_EN
                ,
                .sq       (sq_out[gi])
`endif
            );
        end
    endgenerate

endmodule : multi_tick_gen

// File: tb/tb_multi_tick_gen.sv
// ----------------------------------------------------------------------------
// tb_multi_tick_gen
//   Self-checking bench for multi_tick_gen. Three channels, 16-bit counters and
//   a small reset divisor keep every scenario short. Directed scenarios use
//   closed-form tick positions; the random scenario uses a period-level model.
// ----------------------------------------------------------------------------
module tb_multi_tick_gen;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 20;
    localparam int CH_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] en;
    logic              sync_clr;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              wr_ack;
    logic              wr_err;
    logic [NUM_CH-1:0] div_pending;
    logic [NUM_CH-1:0] tick;
`ifdef MULTI_TICK_GEN_SQUARE_EN
    logic [NUM_CH-1:0] sq_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_tick_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_div      (wr_div),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .div_pending (div_pending),
        .tick        (tick)
`ifdef MULTI_TICK_GEN_SQUARE_EN
        ,
        .sq_out      (sq_out)
`endif
    );

    // One clock: outputs are sampled 1 time unit after the edge, and inputs
    // for the next cycle are driven from the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = '0;
        sync_clr = 1'b0;
        wr_en    = 1'b0;
        wr_ch    = '0;
        wr_div   = '0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset");
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick got %b want 000", tick); end
        checks++; if (div_pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b want 000", div_pending); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
`ifdef MULTI_TICK_GEN_SQUARE_EN
        checks++; if (sq_out !== 3'b000) begin errors++; $display("FAIL reset_sq got %b want 000", sq_out); end
`endif
    endtask

    // Channel 0 on the reset divisor: tick every DEF_DIV+1 cycles from enable.
    task automatic test_default_div();
        $display("test_default_div");
        en = 3'b001;
        for (int n = 1; n <= 2 * (DEF_DIV + 1); n++) begin
            step();
            checks++;
            if (tick[0] !== ((n % (DEF_DIV + 1)) == 0)) begin
                errors++; $display("FAIL default_tick n=%0d got %b want %b", n, tick[0], (n % (DEF_DIV + 1)) == 0);
            end
        end
        en = '0;
        step();
    endtask

    task automatic test_write_disabled();
        $display("test_write_disabled: write ch=1 div=3");
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd3;
        step();
        wr_en = 1'b0;
        checks++; if (wr_ack !== 1'b1) begin errors++; $display("FAIL wd_ack got %b want 1", wr_ack); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wd_err got %b want 0", wr_err); end
        checks++; if (div_pending[1] !== 1'b0) begin errors++; $display("FAIL wd_pending got %b want 0", div_pending[1]); end
        en = 3'b010;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 1) begin
                checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL wd_ack_pulse got %b want 0", wr_ack); end
            end
            checks++;
            if (tick[1] !== ((n % 4) == 0)) begin
                errors++; $display("FAIL wd_tick n=%0d got %b want %b", n, tick[1], (n % 4) == 0);
            end
        end
        en = '0;
        step();
    endtask

    // ch2 runs with div 9; a write of 2 at cnt 5 waits for the period to end.
    task automatic test_shadow();
        logic exp_t, exp_p;
        $display("test_shadow: write ch=2 div=9, then div=2 mid-period");
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd9;
        step();
        wr_en = 1'b0;
        en = 3'b100;
        for (int n = 1; n <= 19; n++) begin
            if (n == 6) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd2;
            end else begin
                wr_en = 1'b0;
            end
            step();
            exp_t = (n == 10) || (n > 10 && ((n - 10) % 3) == 0);
            exp_p = (n >= 6) && (n < 10);
            checks++;
            if (tick[2] !== exp_t) begin errors++; $display("FAIL sh_tick n=%0d got %b want %b", n, tick[2], exp_t); end
            checks++;
            if (div_pending[2] !== exp_p) begin errors++; $display("FAIL sh_pending n=%0d got %b want %b", n, div_pending[2], exp_p); end
        end
        wr_en = 1'b0;
        en = '0;
        step();
    endtask

    // ch1 div 4; write div 1 in the terminal-count cycle -> bypass.
    task automatic test_bypass();
        logic exp_t;
        $display("test_bypass: write ch=1 div=4, then div=1 at terminal count");
        wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd4;
        step();
        wr_en = 1'b0;
        en = 3'b010;
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) begin
                wr_en = 1'b1; wr_ch = 2'd1; wr_div = 16'd1;
            end else begin
                wr_en = 1'b0;
            end
            step();
            exp_t = (n == 5) || (n > 5 && ((n - 5) % 2) == 0);
            checks++;
            if (tick[1] !== exp_t) begin errors++; $display("FAIL bp_tick n=%0d got %b want %b", n, tick[1], exp_t); end
            checks++;
            if (div_pending[1] !== 1'b0) begin errors++; $display("FAIL bp_pending n=%0d got %b want 0", n, div_pending[1]); end
        end
        wr_en = 1'b0;
        en = '0;
        step();
    endtask

    // Out-of-range write must leave ch0=20, ch1=1, ch2=2 untouched.
    task automatic test_bad_channel();
        logic [2:0] exp_t;
        $display("test_bad_channel: write ch=3 div=7");
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 16'd7;
        step();
        wr_en = 1'b0;
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL bad_err got %b want 1", wr_err); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL bad_ack got %b want 0", wr_ack); end
        checks++; if (div_pending !== 3'b000) begin errors++; $display("FAIL bad_pending got %b want 000", div_pending); end
        en = 3'b111;
        for (int n = 1; n <= 42; n++) begin
            step();
            if (n == 1) begin
                checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got %b want 0", wr_err); end
            end
            exp_t = {(n % 3) == 0, (n % 2) == 0, (n % (DEF_DIV + 1)) == 0};
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL bad_tick n=%0d got %b want %b", n, tick, exp_t); end
        end
        en = '0;
        step();
    endtask

    // ch0 div 0: tick every enabled cycle; channels left running afterwards.
    task automatic test_div_zero();
        $display("test_div_zero: write ch=0 div=0");
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 16'd0;
        step();
        wr_en = 1'b0;
        en = 3'b111;
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++;
            if (tick[0] !== 1'b1) begin errors++; $display("FAIL d0_tick n=%0d got %b want 1", n, tick[0]); end
        end
    endtask

    // Divs 0/1/2 running. Pend div 5 on ch2, then sync_clr with a write of 4
    // to ch1; afterwards all restart from 0 with divs 0/4/5.
    task automatic test_sync_clr();
        logic [2:0] exp_t;
        $display("test_sync_clr: pending write ch=2 div=5, clear with write ch=1 div=4");
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd5;
        step();
        checks++; if (div_pending !== 3'b100) begin errors++; $display("FAIL sc_pend_before got %b want 100", div_pending); end
        wr_ch = 2'd1; wr_div = 16'd4;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        wr_en = 1'b0;
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL sc_tick got %b want 000", tick); end
        checks++; if (div_pending !== 3'b000) begin errors++; $display("FAIL sc_pending got %b want 000", div_pending); end
`ifdef MULTI_TICK_GEN_SQUARE_EN
        checks++; if (sq_out !== 3'b000) begin errors++; $display("FAIL sc_sq got %b want 000", sq_out); end
`endif
        for (int n = 1; n <= 30; n++) begin
            step();
            exp_t = {(n % 6) == 0, (n % 5) == 0, 1'b1};
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL sc_tick_after n=%0d got %b want %b", n, tick, exp_t); end
`ifdef MULTI_TICK_GEN_SQUARE_EN
            exp_t = {((n / 6) % 2) == 1, ((n / 5) % 2) == 1, (n % 2) == 1};
            checks++;
            if (sq_out !== exp_t) begin errors++; $display("FAIL sc_sq_after n=%0d got %b want %b", n, sq_out, exp_t); end
`endif
        end
    endtask

    // Reset mid-count with a pending write: all state back to DEF_DIV at once.
    task automatic test_reset_mid();
        logic [2:0] exp_t;
        $display("test_reset_mid: pending write ch=2 div=7, then rst_n low");
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 16'd7;
        step();
        wr_en = 1'b0;
        checks++; if (div_pending[2] !== 1'b1) begin errors++; $display("FAIL rm_pend_before got %b want 1", div_pending[2]); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (tick !== 3'b000) begin errors++; $display("FAIL rm_tick got %b want 000", tick); end
        checks++; if (div_pending !== 3'b000) begin errors++; $display("FAIL rm_pending got %b want 000", div_pending); end
        checks++; if (wr_ack !== 1'b0) begin errors++; $display("FAIL rm_ack got %b want 0", wr_ack); end
        step();
        rst_n = 1'b1;
        for (int n = 1; n <= 2 * (DEF_DIV + 1); n++) begin
            step();
            exp_t = ((n % (DEF_DIV + 1)) == 0) ? 3'b111 : 3'b000;
            checks++;
            if (tick !== exp_t) begin errors++; $display("FAIL rm_tick_after n=%0d got %b want %b", n, tick, exp_t); end
        end
        en = '0;
        step();
    endtask

    // Random traffic against a per-channel period model: each channel knows
    // its period length, how far into the current period it is, and an
    // optional deferred divisor.
    task automatic test_random();
        int          elapsed [NUM_CH];
        int          period_div [NUM_CH];
        int          deferred [NUM_CH];   // -1: nothing deferred
        int          last_written [NUM_CH];
        logic [2:0]  exp_tick, exp_pend;
        logic [2:0]  exp_sq;
        logic        exp_ack, exp_err;
        logic        boundary, hit;
        do_reset();
        $display("test_random");
        for (int c = 0; c < NUM_CH; c++) begin
            elapsed[c] = 0; period_div[c] = DEF_DIV; deferred[c] = -1; last_written[c] = DEF_DIV;
        end
        exp_sq = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
            end
            sync_clr = ($urandom_range(0, 63) == 0);
            wr_en    = ($urandom_range(0, 7) == 0);
            wr_ch    = CH_W'($urandom_range(0, 3));
            wr_div   = CNT_W'($urandom_range(0, 7));
            if (wr_en) $display("  cycle %0d write ch=%0d div=%0d clr=%0d en=%b", cyc, wr_ch, wr_div, sync_clr, en);

            exp_ack = wr_en && (int'(wr_ch) < NUM_CH);
            exp_err = wr_en && (int'(wr_ch) >= NUM_CH);
            for (int c = 0; c < NUM_CH; c++) begin
                hit = wr_en && (int'(wr_ch) == c);
                if (hit) last_written[c] = int'(wr_div);
                boundary = en[c] && (elapsed[c] == period_div[c]);
                exp_tick[c] = boundary && !sync_clr;
                if (exp_tick[c]) exp_sq[c] = ~exp_sq[c];
                if (sync_clr) exp_sq[c] = 1'b0;
                if (sync_clr || !en[c] || boundary) begin
                    elapsed[c] = 0;
                    if (hit) period_div[c] = int'(wr_div);
                    else if (deferred[c] >= 0) period_div[c] = last_written[c];
                    deferred[c] = -1;
                end else begin
                    elapsed[c] = elapsed[c] + 1;
                    if (hit) deferred[c] = int'(wr_div);
                end
                exp_pend[c] = (deferred[c] >= 0);
            end
            step();
            checks++;
            if (tick !== exp_tick) begin errors++; $display("FAIL rnd_tick cyc=%0d got %b want %b", cyc, tick, exp_tick); end
            checks++;
            if (div_pending !== exp_pend) begin errors++; $display("FAIL rnd_pending cyc=%0d got %b want %b", cyc, div_pending, exp_pend); end
            checks++;
            if ({wr_ack, wr_err} !== {exp_ack, exp_err}) begin
                errors++; $display("FAIL rnd_ack_err cyc=%0d got %b%b want %b%b", cyc, wr_ack, wr_err, exp_ack, exp_err);
            end
`ifdef MULTI_TICK_GEN_SQUARE_EN
            checks++;
            if (sq_out !== exp_sq) begin errors++; $display("FAIL rnd_sq cyc=%0d got %b want %b", cyc, sq_out, exp_sq); end
`endif
        end
        wr_en = 1'b0;
        sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_write_disabled();
        test_shadow();
        test_bypass();
        test_bad_channel();
        test_div_zero();
        test_sync_clr();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_multi_tick_gen
